ifetch: RTL and testbench

Instruction fetch sequencer that produces the `ins` and `en_in` inputs consumed by the CPU instruction register. It owns the program counter and runs a req/ack read handshake to instruction memory. It delivers each fetched word as a one-cycle `en_in` strobe with `ins` held stable. It sits between the control unit (fetch requests, PC redirects) and instruction memory.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifetch_pc_reg.sv | 27 ++
 rtl/ifetch.sv | 133 +++++++++++++
 tb/tb_ifetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM encoding and default sizes.
// Imported by ifetch and pc_reg.
package cpu_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int RESET_PC_DEF = 0;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_t;

  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter with synchronous reset, load and wrapping increment.
// Load wins over increment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch sequencer: owns the PC, runs the req/ack
// handshake to imem and strobes each word into the IR.
module ifetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ins,
  output logic              en_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  fetch_state_t      state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] ins_n;
  logic              en_n;
  logic              busy_n;
  logic              terr_n;
  logic              pc_ld;
  logic              pc_inc;
  logic              expired;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_ld),
    .inc     (pc_inc),
    .load_val(pc_in),
    .pc      (pc_out)
  );

  // in REQ the PC always equals mem_addr, so inc gives mem_addr+1
  assign expired = (TIMEOUT != 0) && (cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = mem_req;
    addr_n  = mem_addr;
    ins_n   = ins;
    en_n    = 1'b0;
    busy_n  = busy;
    terr_n  = timeout_err;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pc_load) begin
          pc_ld  = 1'b1;
          terr_n = 1'b0;
        end
        if (fetch_req) begin
          req_n   = 1'b1;
          addr_n  = pc_load ? pc_in : pc_out;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          ins_n   = mem_rdata;
          en_n    = 1'b1;
          req_n   = 1'b0;
          pc_inc  = 1'b1;
          state_n = S_DONE;
        end else if (expired) begin
          req_n   = 1'b0;
          terr_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        req_n   = 1'b0;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ins         <= '0;
      en_in       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mem_req     <= req_n;
      mem_addr    <= addr_n;
      ins         <= ins_n;
      en_in       <= en_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed table, reset-in-flight
// sequence and randomized transactions against a transaction model.
module tb_ifetch;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic          pc_load;
  logic [AW-1:0] pc_in;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ins;
  logic          en_in;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  ifetch #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(0),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .ins        (ins),
    .en_in      (en_in),
    .pc_out     (pc_out),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] mpc;
  logic [DW-1:0] mins;
  logic          mterr;

  typedef struct {
    bit            ld;
    logic [AW-1:0] tgt;
    int            waits;
    logic [DW-1:0] data;
    bit            noise;
    logic [AW-1:0] eaddr;
    int            ecyc;
    bit            eok;
    logic [AW-1:0] epc;
    bit            eterr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    mem_ack   = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mpc   = '0;
    mins  = '0;
    mterr = 1'b0;
  endtask

  task automatic load_only(input logic [AW-1:0] tgt);
    pc_load = 1'b1;
    pc_in   = tgt;
    step();
    pc_load = 1'b0;
    chk("ld_pc", 32'(pc_out), 32'(tgt));
    chk("ld_terr", 32'(timeout_err), 0);
    chk("ld_busy", 32'(busy), 0);
    chk("ld_req", 32'(mem_req), 0);
    mpc   = tgt;
    mterr = 1'b0;
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      mem_ack   = 1'($urandom);
      mem_rdata = 16'($urandom);
      step();
      chk("gap_en", 32'(en_in), 0);
      chk("gap_req", 32'(mem_req), 0);
      chk("gap_ins", 32'(ins), 32'(mins));
      chk("gap_pc", 32'(pc_out), 32'(mpc));
    end
    mem_ack = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    fetch_req = 1'b1;
    pc_load   = v.ld;
    pc_in     = v.tgt;
    mem_ack   = 1'b0;
    step();
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      chk("req_addr", 32'(mem_addr), 32'(v.eaddr));
      chk("req_busy", 32'(busy), 1);
      chk("req_en", 32'(en_in), 0);
      mem_ack   = (n == v.waits + 1);
      mem_rdata = mem_ack ? v.data : 16'($urandom);
      if (v.noise) begin
        fetch_req = 1'($urandom);
        pc_load   = 1'($urandom);
        pc_in     = 8'($urandom);
      end
      step();
    end
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    mem_ack   = 1'b0;
    chk("req_cycles", 32'(n), 32'(v.ecyc));
    if (n >= 40) begin
      do_reset(2);
      return;
    end
    if (v.eok) begin
      chk("done_en", 32'(en_in), 1);
      chk("done_ins", 32'(ins), 32'(v.data));
      chk("done_pc", 32'(pc_out), 32'(v.epc));
      chk("done_busy", 32'(busy), 1);
      chk("done_terr", 32'(timeout_err), 32'(v.eterr));
      if (v.noise) begin
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_in     = 8'($urandom);
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
      end
      step();
      fetch_req = 1'b0;
      pc_load   = 1'b0;
      mem_ack   = 1'b0;
      chk("idle_en", 32'(en_in), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_req", 32'(mem_req), 0);
      chk("idle_ins", 32'(ins), 32'(v.data));
      chk("idle_pc", 32'(pc_out), 32'(v.epc));
      mins = v.data;
    end else begin
      chk("to_en", 32'(en_in), 0);
      chk("to_busy", 32'(busy), 0);
      chk("to_terr", 32'(timeout_err), 1);
      chk("to_pc", 32'(pc_out), 32'(v.epc));
      chk("to_ins", 32'(ins), 32'(mins));
    end
    mpc   = v.epc;
    mterr = v.eterr;
  endtask

  // expected results straight from the fetch rules, no cycle model
  task automatic model_txn(input bit ld, input logic [AW-1:0] tgt,
                           input int waits, input bit noise);
    vec_t v;
    v.ld    = ld;
    v.tgt   = tgt;
    v.waits = waits;
    v.data  = 16'($urandom);
    v.noise = noise;
    v.eaddr = ld ? tgt : mpc;
    v.eok   = (waits + 1 <= TO);
    v.ecyc  = v.eok ? waits + 1 : TO;
    v.epc   = v.eok ? v.eaddr + 8'd1 : v.eaddr;
    v.eterr = v.eok ? (ld ? 1'b0 : mterr) : 1'b1;
    run_txn(v);
  endtask

  initial begin
    pc_in     = '0;
    mem_rdata = '0;
    do_reset(2);
    rst = 1'b1;
    step();
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_en", 32'(en_in), 0);
    chk("rst_ins", 32'(ins), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    rst = 1'b0;

    tbl[0] = '{0, 8'h00, 0, 16'hA5C3, 0, 8'h00, 1, 1, 8'h01, 0};
    tbl[1] = '{0, 8'h00, 2, 16'h1234, 0, 8'hFF, 3, 1, 8'h00, 0};
    tbl[2] = '{1, 8'h40, 0, 16'hBEEF, 1, 8'h40, 1, 1, 8'h41, 0};
    tbl[3] = '{0, 8'h00, 1, 16'h0F0F, 1, 8'h41, 2, 1, 8'h42, 0};
    tbl[4] = '{0, 8'h00, 30, 16'hDEAD, 1, 8'h42, 15, 0, 8'h42, 1};
    tbl[5] = '{1, 8'h10, 14, 16'h5555, 0, 8'h10, 15, 1, 8'h11, 0};
    for (int i = 0; i < 6; i++) begin
      if (i == 1) load_only(8'hFF);
      run_txn(tbl[i]);
    end

    model_txn(0, 8'h00, 40, 0);
    chk("terr_sticky", 32'(timeout_err), 1);
    idle_gap(2);
    chk("terr_hold", 32'(timeout_err), 1);
    load_only(8'h20);

    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("r6_req1", 32'(mem_req), 1);
    step();
    chk("r6_req2", 32'(mem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r6_req", 32'(mem_req), 0);
    chk("r6_busy", 32'(busy), 0);
    chk("r6_pc", 32'(pc_out), 0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hCAFE;
    step();
    mem_ack = 1'b0;
    chk("r6_late_en", 32'(en_in), 0);
    chk("r6_late_ins", 32'(ins), 0);
    step();
    chk("r6_late_en2", 32'(en_in), 0);
    mpc   = '0;
    mins  = '0;
    mterr = 1'b0;

    for (int i = 0; i < 60; i++) begin
      int w;
      int r;
      r = int'($urandom_range(0, 9));
      w = (r < 7) ? int'($urandom_range(0, 4)) :
          (r == 7) ? 14 : (r == 8) ? 15 : 20;
      if ($urandom_range(0, 5) == 0) load_only(8'($urandom));
      model_txn(($urandom_range(0, 3) == 0), 8'($urandom), w,
                1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
